// File: rtl/rst_sequencer.sv
// rst_sequencer: configurable power-on hold then ordered, staged release of NUM_STAGES reset domains
// Optional RUN-state watchdog trigger enabled by defining RST_SEQ_WATCHDOG_EN.
module rst_sequencer #(
    parameter int NUM_STAGES      = 3,
    parameter int HOLD_CYCLES     = 25,
    parameter int STAGE_GAP       = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
`ifdef RST_SEQ_WATCHDOG_EN
    ,
    parameter int WDT_CYCLES      = 1024
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_in,
    input  logic                  soft_rst_req,
`ifdef RST_SEQ_WATCHDOG_EN
    input  logic                  wdt_kick,
    output logic                  wdt_fired,
`endif
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  seq_done,
    output logic [7:0]            seq_count
);
    typedef enum logic [1:0] {ASSERT, RELEASE, RUN} state_t;
    state_t                state, state_d;
    logic [1:0]            sync;
    logic                  btn_lvl;
    logic [CNT_W-1:0]      db_cnt, hold_cnt, hold_cnt_d, gap_cnt, gap_cnt_d;
    logic [NUM_STAGES-1:0] rst_out_d, shifted;
    logic [7:0]            seq_count_d;
    logic                  trig, adv, wdt_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync    <= '0;
            btn_lvl <= 1'b0;
            db_cnt  <= '0;
        end else begin
            sync <= {sync[0], btn_in};
            if (sync[1] == btn_lvl) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_lvl <= sync[1];
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

`ifdef RST_SEQ_WATCHDOG_EN
    logic [CNT_W-1:0] wdt_cnt;
    assign wdt_hit = (state == RUN) && (wdt_cnt == CNT_W'(WDT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_cnt   <= '0;
            wdt_fired <= 1'b0;
        end else begin
            wdt_cnt   <= (state != RUN || wdt_kick || trig) ? '0 : wdt_cnt + 1'b1;
            wdt_fired <= wdt_fired | wdt_hit;
        end
    end
`else
    assign wdt_hit = 1'b0;
`endif

    assign trig     = btn_lvl | soft_rst_req | wdt_hit;
    assign adv      = (state == ASSERT && hold_cnt == CNT_W'(HOLD_CYCLES)) ||
                      (state == RELEASE && gap_cnt == CNT_W'(STAGE_GAP));
    // Bit 0 releases first, so each release shifts the asserted mask up by one.
    assign shifted  = rst_out << 1;
    assign seq_done = (state == RUN);

    always_comb begin
        state_d     = trig ? ASSERT : !adv ? state : (shifted == '0) ? RUN : RELEASE;
        rst_out_d   = trig ? '1 : adv ? shifted : rst_out;
        hold_cnt_d  = (trig || adv || state != ASSERT) ? '0 : hold_cnt + 1'b1;
        gap_cnt_d   = trig ? '0 : adv ? CNT_W'(1) : (state == RELEASE) ? gap_cnt + 1'b1 : '0;
        seq_count_d = (!trig && adv && shifted == '0 && seq_count != 8'hff) ? seq_count + 8'd1 : seq_count;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ASSERT;
            rst_out   <= '1;
            hold_cnt  <= '0;
            gap_cnt   <= '0;
            seq_count <= '0;
        end else begin
            state     <= state_d;
            rst_out   <= rst_out_d;
            hold_cnt  <= hold_cnt_d;
            gap_cnt   <= gap_cnt_d;
            seq_count <= seq_count_d;
        end
    end
endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: default-parameter sequencer plus a 1-stage/1-cycle instance for count saturation
module tb_rst_sequencer;
    localparam int D = 16;
    localparam int W = 8;
`ifdef RST_SEQ_WATCHDOG_EN
    localparam bit WDT_ON = 1'b1;
    logic fired_a, fired_b;
`else
    localparam bit WDT_ON = 1'b0;
`endif
    logic       clk = 1'b0, rst = 1'b1;
    logic       btn_a = 1'b0, soft_a = 1'b0, kick_a = 1'b0;
    logic       btn_b = 1'b0, soft_b = 1'b0, kick_b = 1'b1;
    logic [2:0] rout_a;
    logic [0:0] rout_b;
    logic       done_a, done_b;
    logic [7:0] cnt_a, cnt_b;
    int         tests = 0, fails = 0, e_now = -1;
    bit         kick_en = 1'b1, b_done = 1'b0;
    int         hp[2] = '{25, 1};
    int         gp[2] = '{4, 1};
    int         np[2] = '{3, 1};
    int         n[2], cnt[2], streak[2], wq[2];
    bit         lvl[2], sv[2], s0[2], s1[2], wfired[2];

    always #5 clk = ~clk;

    rst_sequencer #(
`ifdef RST_SEQ_WATCHDOG_EN
        .WDT_CYCLES(8),
`endif
        .NUM_STAGES(3)
    ) dut_a (
        .clk(clk), .rst(rst), .btn_in(btn_a), .soft_rst_req(soft_a),
`ifdef RST_SEQ_WATCHDOG_EN
        .wdt_kick(kick_a), .wdt_fired(fired_a),
`endif
        .rst_out(rout_a), .seq_done(done_a), .seq_count(cnt_a)
    );

    rst_sequencer #(
`ifdef RST_SEQ_WATCHDOG_EN
        .WDT_CYCLES(8),
`endif
        .NUM_STAGES(1), .HOLD_CYCLES(1), .STAGE_GAP(1)
    ) dut_b (
        .clk(clk), .rst(rst), .btn_in(btn_b), .soft_rst_req(soft_b),
`ifdef RST_SEQ_WATCHDOG_EN
        .wdt_kick(kick_b), .wdt_fired(fired_b),
`endif
        .rst_out(rout_b), .seq_done(done_b), .seq_count(cnt_b)
    );

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic wait_edge(input int x);
        while (e_now < x) @(negedge clk);
    endtask

    // Stages released after n quiet edges since the last trigger or reset.
    function automatic int rel(input int i, input int nn);
        int r;
        if (nn < hp[i] + 1) return 0;
        r = (nn - hp[i] - 1) / gp[i] + 1;
        return (r > np[i]) ? np[i] : r;
    endfunction

    function automatic int exp_rst(input int i);
        return ((1 << np[i]) - 1) & ~((1 << rel(i, n[i])) - 1);
    endfunction

    always @(posedge clk) e_now <= rst ? -1 : e_now + 1;

    always @(posedge clk) begin : model
        bit s, dp, wt, tg, sft, kk;
        int fin;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                n[i] = 0; cnt[i] = 0; streak[i] = 0; wq[i] = 0;
                lvl[i] = 0; sv[i] = 0; s0[i] = 0; s1[i] = 0; wfired[i] = 0;
            end else begin
                s     = s1[i];
                s1[i] = s0[i];
                s0[i] = (i == 0) ? btn_a : btn_b;
                sft   = (i == 0) ? soft_a : soft_b;
                kk    = (i == 0) ? kick_a : kick_b;
                dp    = rel(i, n[i]) == np[i];
                wt    = WDT_ON && dp && wq[i] == W;
                tg    = lvl[i] | sft | wt;
                wfired[i] |= wt;
                wq[i] = (!dp || kk || tg) ? 0 : wq[i] + 1;
                fin   = hp[i] + 1 + (np[i] - 1) * gp[i];
                n[i]  = tg ? 0 : (n[i] > fin ? n[i] : n[i] + 1);
                if (!tg && n[i] == fin && cnt[i] < 255) cnt[i]++;
                streak[i] = (s == sv[i]) ? (streak[i] < D ? streak[i] + 1 : D) : 1;
                sv[i] = s;
                if (s != lvl[i] && streak[i] >= D) lvl[i] = s;
            end
        end
    end

    always @(negedge clk) begin
        chk("a_rst_out", rout_a, exp_rst(0));
        chk("a_seq_done", done_a, rel(0, n[0]) == np[0]);
        chk("a_seq_count", cnt_a, cnt[0]);
        chk("b_rst_out", rout_b, exp_rst(1));
        chk("b_seq_done", done_b, rel(1, n[1]) == np[1]);
        chk("b_seq_count", cnt_b, cnt[1]);
`ifdef RST_SEQ_WATCHDOG_EN
        chk("a_wdt_fired", fired_a, wfired[0]);
        chk("b_wdt_fired", fired_b, wfired[1]);
`endif
    end

    initial forever begin
        repeat (4) @(negedge clk);
        kick_a = kick_en;
        @(negedge clk);
        kick_a = 1'b0;
    end

    initial begin
        @(negedge clk);
        while (rst) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("b_first_seq", cnt_b, 1);
        for (int j = 0; j < 300; j++) begin
            soft_b = 1'b1;
            @(negedge clk);
            soft_b = 1'b0;
            repeat (2) @(negedge clk);
            if (j == 0 || j == 252 || j == 253 || j == 299)
                chk($sformatf("b_count_after_%0d", j + 1), cnt_b, (j + 2 > 255) ? 255 : j + 2);
        end
        chk("b_rst_out_run", rout_b, 0);
        b_done = 1'b1;
    end

    initial begin
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("reset_rst_out", rout_a, 7);
        chk("reset_seq_done", done_a, 0);
        chk("reset_seq_count", cnt_a, 0);
        rst = 1'b0;
        wait_edge(24);  chk("t1_e24", rout_a, 7);
        wait_edge(25);  chk("t1_e25", rout_a, 6);
        wait_edge(28);  chk("t1_e28", rout_a, 6);
        wait_edge(29);  chk("t1_e29", rout_a, 4);
        wait_edge(32);  chk("t1_e32_done", done_a, 0);
        wait_edge(33);  chk("t1_e33", rout_a, 0); chk("t1_done", done_a, 1); chk("t1_count", cnt_a, 1);
        wait_edge(39);  soft_a = 1'b1;
        wait_edge(40);  soft_a = 1'b0; chk("t2_e40", rout_a, 7); chk("t2_done", done_a, 0);
        wait_edge(65);  chk("t2_e65", rout_a, 7);
        wait_edge(66);  chk("t2_e66", rout_a, 6);
        wait_edge(70);  chk("t2_e70", rout_a, 4);
        wait_edge(74);  chk("t2_e74", rout_a, 0); chk("t2_count", cnt_a, 2);
        wait_edge(79);  btn_a = 1'b1;
        wait_edge(89);  btn_a = 1'b0;
        wait_edge(110); chk("t3_short_btn", rout_a, 0); chk("t3_short_count", cnt_a, 2);
        wait_edge(119); btn_a = 1'b1;
        wait_edge(137); chk("t3_e137", rout_a, 0);
        wait_edge(138); chk("t3_e138", rout_a, 7);
        wait_edge(150); chk("t3_hold_high", rout_a, 7);
        wait_edge(159); btn_a = 1'b0;
        wait_edge(202); chk("t3_e202", rout_a, 7);
        wait_edge(203); chk("t3_e203", rout_a, 6);
        wait_edge(210); chk("t4_e210", rout_a, 4); soft_a = 1'b1;
        wait_edge(211); soft_a = 1'b0;
        chk("t4_e211", rout_a, 7); chk("t4_done", done_a, 0); chk("t4_count", cnt_a, 2);
        wait_edge(245); chk("t4_e245", rout_a, 0); chk("t4_done_run", done_a, 1); chk("t4_count_run", cnt_a, 3);
`ifdef RST_SEQ_WATCHDOG_EN
        wait_edge(300); chk("t6_kicked_done", done_a, 1); chk("t6_kicked_fired", fired_a, 0);
        kick_en = 1'b0;
        wait_edge(320); chk("t6_fired", fired_a, 1); chk("t6_rst_out", rout_a, 7);
        wait_edge(420); chk("t6_sticky", fired_a, 1);
`endif
        for (int k = 0; k < 3000 && !b_done; k++) @(negedge clk);
        chk("b_finished", b_done, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("final_rst_out_a", rout_a, 7);
        chk("final_done_a", done_a, 0);
        chk("final_count_a", cnt_a, 0);
        chk("final_rst_out_b", rout_b, 1);
        chk("final_count_b", cnt_b, 0);
`ifdef RST_SEQ_WATCHDOG_EN
        chk("final_fired_a", fired_a, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Synthesizable, parametrised reset sequencer for the riscv_top SoC.
- Replaces fixed hold-then-release reset with a configurable power-on hold and staged, ordered release of NUM_STAGES reset domains (e.g. memory/bus, then CPU core, then UART/peripherals).
- Also accepts a debounced raw push-button and a software reset request.
- Sits between the board clock/reset input and all downstream reset consumers.

Parameters:
- NUM_STAGES, 3: number of reset domains; bit 0 is released first. Minimum 1.
- HOLD_CYCLES, 25: cycles every output is held asserted before stage 0 is released. Minimum 1.
- STAGE_GAP, 4: cycles between consecutive stage releases. Minimum 1.
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required to change the debounced button level. Minimum 1.
- CNT_W, 16: width of the internal hold, gap and debounce counters. Must hold the largest of the above.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- btn_in  input  1  raw asynchronous push-button, active-high.
- soft_rst_req  input  1  single-cycle software reset request.
- rst_out  output  NUM_STAGES  per-domain reset, active-high.
- seq_done  output  1  high while all stages are released.
- seq_count  output  8  number of completed sequences, saturating.

Behaviour:
- Interface: one clock, clk. Reset is rst, synchronous and active-high.
- Reset values while rst=1:
  - state=ASSERT, all counters 0.
  - rst_out all ones, seq_done=0, seq_count=0.
  - Synchronizer flops 0, debounced level 0.
  - soft_rst_req ignored.
- Button path:
  - btn_in passes through a 2-flop synchronizer.
  - The debounced level flips when the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive edges.
  - Any agreeing cycle clears the debounce counter.
- Trigger = (debounced level high) OR soft_rst_req.
- State ASSERT:
  - rst_out all ones.
  - The hold counter increments each edge with no trigger. A trigger clears it to 0.
  - The hold counter is held at 0 while the debounced level is high.
  - When the counter reaches HOLD_CYCLES: rst_out[0] clears on that same edge, go to RELEASE (or RUN if NUM_STAGES=1).
- State RELEASE:
  - rst_out[k] clears STAGE_GAP edges after rst_out[k-1] clears.
  - Released bits stay low.
  - On the edge rst_out[NUM_STAGES-1] clears: go to RUN, seq_done=1, seq_count+1, saturating at 255.
- State RUN:
  - rst_out all zero, seq_done=1.
- Trigger from any state:
  - Next edge: state=ASSERT, rst_out all ones, seq_done=0, all hold/gap counters 0.
- Simultaneous events:
  - A trigger on the edge of the final stage release wins: no RUN entry, seq_count unchanged.
  - rst overrides everything.
- rst_out only changes on clk edges; there is no combinational path from any input to rst_out.

Optional Feature:
- Macro: RST_SEQ_WATCHDOG_EN.
- With it defined:
  - Adds parameter WDT_CYCLES (default 1024), input wdt_kick (1 bit) and output wdt_fired (1 bit, reset 0).
  - In RUN, a watchdog counter increments each edge and clears on wdt_kick.
  - On reaching WDT_CYCLES it acts as a trigger and sets wdt_fired.
  - wdt_fired is sticky; only rst clears it.
  - The watchdog counter is held at 0 outside RUN.
- Without it: those ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
1. Defaults; rst high 10 edges, then low (edge 0 = first with rst=0) -> rst_out=111 until edge 25; 110 at 25; 100 at 29; 000 at 33. seq_done=1 at 33, seq_count=1.
2. In RUN, soft_rst_req pulse at edge 40 -> rst_out=111 at 41. Stage releases at 66/70/74. seq_count=2.
3. btn_in high for 10 cycles -> no change to rst_out. btn_in high for 40 cycles -> rst_out=111 within 2+16 edges of rise; held 111 until debounced low, then 25-edge hold and staged release.
4. soft_rst_req asserted on the edge stage 2 would release -> rst_out=111 next edge, seq_done stays 0, seq_count unchanged.
5. HOLD_CYCLES=1, STAGE_GAP=1, NUM_STAGES=1; 300 soft_rst_req pulses, each after a completed sequence -> seq_count saturates at 255.
6. RST_SEQ_WATCHDOG_EN with WDT_CYCLES=8, no kicks after RUN -> trigger after 8 edges, rst_out=111, wdt_fired=1 and sticky until rst. With a kick every 5 edges -> no trigger.
